// File: rtl/dr_pkg.sv
// Shared types for the data-router blocks: register-array commands, bank count and
// the row-register sequencer state encoding.
package dr_pkg;

  localparam int unsigned DR_NBANK = 4;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    CLEAR = 2'd3
  } reg_array_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StShift,
    StDrain,
    StDone
  } seq_state_e;

endpackage

// File: rtl/reg_array_seq_if.sv
// Bundle of the sequencer's tile-control, line-buffer, register-array and PE-array signals.
// The master side is the sequencer; the slave side is its environment.
interface reg_array_seq_if
  import dr_pkg::*;
#(
  parameter int unsigned ROWW = 16
) ();

  logic            start;
  logic [ROWW-1:0] cfg_rows;
  logic [1:0]      cfg_bank0;
  logic            busy;
  logic            done;

  logic            buf_valid;
  logic            buf_rd;

  reg_array_cmd_e  reg_array_cmd;
  logic [1:0]      bank;

  logic            pe_valid;
  logic            pe_ready;
  logic [1:0]      pe_kx;
  logic [1:0]      pe_ky;
  logic            pe_last;

  modport master (
    input  start, cfg_rows, cfg_bank0, buf_valid, pe_ready,
    output busy, done, buf_rd, reg_array_cmd, bank, pe_valid, pe_kx, pe_ky, pe_last
  );

  modport slave (
    output start, cfg_rows, cfg_bank0, buf_valid, pe_ready,
    input  busy, done, buf_rd, reg_array_cmd, bank, pe_valid, pe_kx, pe_ky, pe_last
  );

endinterface

// File: rtl/reg_array_seq_wrap_counter.sv
// Modulo counter with synchronous clear; wrap_o flags the increment that returns to zero.
module wrap_counter #(
  parameter int unsigned Width = 2,
  parameter int unsigned Max   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic             wrap_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = inc_i && (cnt_q == Width'(Max));
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_array_seq.sv
// Row-register-array sequencer: per output row, one LOAD per kernel row followed by
// KSIZE-1 SHIFTs, paced by line-buffer availability and PE-array backpressure.
module reg_array_seq
  import dr_pkg::*;
#(
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned NBANK  = DR_NBANK,
  parameter int unsigned ROWW   = 16
) (
  input logic                clk,
  input logic                rst,
  reg_array_seq_if.master    bus_io
);

  localparam logic [1:0] BankMask = 2'(NBANK - 1);

  seq_state_e      state_q, state_d;
  logic [ROWW-1:0] rows_q, rows_d;
  logic [ROWW-1:0] row_q, row_d;
  logic [1:0]      base_q, base_d;

  logic            pe_valid_q, pe_valid_d;
  logic [1:0]      pe_kx_q, pe_kx_d;
  logic [1:0]      pe_ky_q, pe_ky_d;
  logic            pe_last_q, pe_last_d;

  logic [1:0]      kx, ky;
  logic            kx_wrap, ky_wrap;
  logic            adv, accept, issue_load, issue_shift, issue;
  logic            last_row, tile_end;
  reg_array_cmd_e  cmd;
  logic            buf_rd;

  // A new beat may only be issued when the output stage is empty or being drained.
  assign adv         = !pe_valid_q || bus_io.pe_ready;
  assign accept      = (state_q == StIdle) && bus_io.start;
  assign issue_load  = (state_q == StLoad) && bus_io.buf_valid && adv;
  assign issue_shift = (state_q == StShift) && adv;
  assign issue       = issue_load || issue_shift;

  assign last_row = (row_q == rows_q - ROWW'(1));
  assign tile_end = kx_wrap && last_row && (ky == 2'(KSIZE - 1));

  wrap_counter #(
    .Width (2),
    .Max   (KSIZE - 1)
  ) u_kx_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (accept),
    .inc_i  (issue),
    .cnt_o  (kx),
    .wrap_o (kx_wrap)
  );

  wrap_counter #(
    .Width (2),
    .Max   (KSIZE - 1)
  ) u_ky_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (accept),
    .inc_i  (kx_wrap),
    .cnt_o  (ky),
    .wrap_o (ky_wrap)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = (bus_io.cfg_rows == '0) ? StDone : StClear;
        end
      end
      StClear: state_d = StLoad;
      StLoad: begin
        if (issue_load) begin
          if (kx_wrap) begin
            state_d = tile_end ? StDrain : StLoad;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        if (issue_shift && kx_wrap) begin
          state_d = tile_end ? StDrain : StLoad;
        end
      end
      StDrain: begin
        if (pe_valid_q && bus_io.pe_ready && pe_last_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    cmd    = HOLD;
    buf_rd = 1'b0;
    unique case (state_q)
      StClear: cmd = CLEAR;
      StLoad: begin
        if (issue_load) begin
          cmd    = LOAD;
          buf_rd = 1'b1;
        end
      end
      StShift: begin
        if (issue_shift) begin
          cmd = SHIFT;
        end
      end
      default: cmd = HOLD;
    endcase
  end

  // Tile configuration, row counter and bank row-base
  always_comb begin
    rows_d = rows_q;
    row_d  = row_q;
    base_d = base_q;
    if (accept) begin
      rows_d = bus_io.cfg_rows;
      row_d  = '0;
      base_d = bus_io.cfg_bank0 & BankMask;
    end else if (ky_wrap) begin
      row_d  = row_q + ROWW'(1);
      base_d = (base_q + 2'(STRIDE)) & BankMask;
    end
  end

  // Output beat register; holds its contents while the PE array stalls.
  always_comb begin
    pe_valid_d = pe_valid_q;
    pe_kx_d    = pe_kx_q;
    pe_ky_d    = pe_ky_q;
    pe_last_d  = pe_last_q;
    if (issue) begin
      pe_valid_d = 1'b1;
      pe_kx_d    = kx;
      pe_ky_d    = ky;
      pe_last_d  = tile_end;
    end else if (bus_io.pe_ready) begin
      pe_valid_d = 1'b0;
      pe_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q     <= '0;
      row_q      <= '0;
      base_q     <= '0;
      pe_valid_q <= 1'b0;
      pe_kx_q    <= '0;
      pe_ky_q    <= '0;
      pe_last_q  <= 1'b0;
    end else begin
      rows_q     <= rows_d;
      row_q      <= row_d;
      base_q     <= base_d;
      pe_valid_q <= pe_valid_d;
      pe_kx_q    <= pe_kx_d;
      pe_ky_q    <= pe_ky_d;
      pe_last_q  <= pe_last_d;
    end
  end

  assign bus_io.busy          = (state_q != StIdle);
  assign bus_io.done          = (state_q == StDone);
  assign bus_io.buf_rd        = buf_rd;
  assign bus_io.reg_array_cmd = cmd;
  assign bus_io.bank          = (base_q + ky) & BankMask;
  assign bus_io.pe_valid      = pe_valid_q;
  assign bus_io.pe_kx         = pe_kx_q;
  assign bus_io.pe_ky         = pe_ky_q;
  assign bus_io.pe_last       = pe_last_q;

endmodule

// File: tb/tb_reg_array_seq.sv
// Bench for reg_array_seq: directed latency/stall scenarios plus randomized pacing,
// checked against a window-order model built from nested row/ky/kx loops.
module tb_reg_array_seq;
  import dr_pkg::*;

  localparam int unsigned K = 3;
  localparam int unsigned S = 1;
  localparam int unsigned NB = 4;
  localparam int unsigned RW = 16;
  localparam int TrLen = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_array_seq_if #(.ROWW(RW)) bus ();

  reg_array_seq #(
    .KSIZE  (K),
    .STRIDE (S),
    .NBANK  (NB),
    .ROWW   (RW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_pass = 0;

  reg_array_cmd_e cmd_tr [TrLen];
  logic rd_tr [TrLen], pv_tr [TrLen], pr_tr [TrLen], last_tr [TrLen];
  logic busy_tr [TrLen], done_tr [TrLen];
  logic [1:0] kx_tr [TrLen], ky_tr [TrLen], bank_tr [TrLen];
  logic [4:0] exp_beats[$], obs_beats[$];
  logic [1:0] exp_loads[$], obs_loads[$];
  int ntr;
  int g_mode = 0, g_xs1 = -1, g_xs2 = -1, g_rst = -1;

  // Reference: windows in (row, ky, kx) order; one buffer pop per (row, ky).
  task automatic build_model(input int rows, input int bank0);
    exp_beats.delete();
    exp_loads.delete();
    for (int r = 0; r < rows; r++) begin
      for (int ky = 0; ky < int'(K); ky++) begin
        exp_loads.push_back(2'((bank0 + r * int'(S) + ky) % int'(NB)));
        for (int kx = 0; kx < int'(K); kx++) begin
          exp_beats.push_back({(r == rows - 1 && ky == int'(K) - 1 && kx == int'(K) - 1),
                               ky[1:0], kx[1:0]});
        end
      end
    end
  endtask

  function automatic int beat_errs();
    int e = 0;
    if (obs_beats.size() != exp_beats.size()) e++;
    for (int i = 0; i < exp_beats.size() && i < obs_beats.size(); i++)
      if (obs_beats[i] !== exp_beats[i]) e++;
    return e;
  endfunction

  function automatic int load_errs();
    int e = 0;
    if (obs_loads.size() != exp_loads.size()) e++;
    for (int i = 0; i < exp_loads.size() && i < obs_loads.size(); i++)
      if (obs_loads[i] !== exp_loads[i]) e++;
    return e;
  endfunction

  function automatic int cnt_done();
    int n = 0;
    for (int c = 0; c < ntr; c++) if (done_tr[c]) n++;
    return n;
  endfunction

  function automatic int cnt_rd();
    int n = 0;
    for (int c = 0; c < ntr; c++) if (rd_tr[c]) n++;
    return n;
  endfunction

  // Drives one tile starting at cycle 0 and records outputs once per cycle (negedge).
  task automatic run_tile(input int rows, input int bank0, input int ncyc, output bit got_done);
    int stop_at = -1;
    got_done = 1'b0;
    obs_beats.delete();
    obs_loads.delete();
    ntr = 0;
    for (int c = 0; c < ncyc && c < TrLen; c++) begin
      bus.start     = (c == 0) || (c == g_xs1) || (c == g_xs2);
      bus.cfg_rows  = (c == 0) ? RW'(rows) : RW'($urandom);
      bus.cfg_bank0 = (c == 0) ? 2'(bank0) : 2'($urandom);
      rst           = (c == g_rst);
      case (g_mode)
        1:       begin bus.buf_valid = !(c >= 5 && c <= 8); bus.pe_ready = 1'b1; end
        2:       begin bus.buf_valid = 1'b1; bus.pe_ready = !(c >= 4 && c <= 6); end
        3:       begin
          bus.buf_valid = ($urandom_range(0, 3) != 0);
          bus.pe_ready  = ($urandom_range(0, 3) != 0);
        end
        default: begin bus.buf_valid = 1'b1; bus.pe_ready = 1'b1; end
      endcase
      @(negedge clk);
      cmd_tr[c] = bus.reg_array_cmd;  rd_tr[c] = bus.buf_rd;    pv_tr[c] = bus.pe_valid;
      pr_tr[c] = bus.pe_ready;        last_tr[c] = bus.pe_last; busy_tr[c] = bus.busy;
      done_tr[c] = bus.done;          kx_tr[c] = bus.pe_kx;     ky_tr[c] = bus.pe_ky;
      bank_tr[c] = bus.bank;
      if (bus.pe_valid && bus.pe_ready) obs_beats.push_back({bus.pe_last, bus.pe_ky, bus.pe_kx});
      if (bus.buf_rd) obs_loads.push_back(bus.bank);
      ntr = c + 1;
      if (bus.done && stop_at < 0) begin
        got_done = 1'b1;
        stop_at  = c + 4;
      end
      @(posedge clk);
      #1;
      if (c == stop_at) break;
    end
    bus.start = 1'b0;
    bus.buf_valid = 1'b0;
    bus.pe_ready = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.buf_rd, bus.pe_valid, bus.pe_last} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {bus.busy, bus.done, bus.buf_rd, bus.pe_valid, bus.pe_last});
    else n_pass++;
    n_checks++;
    if ({bus.pe_kx, bus.pe_ky, bus.bank} !== 6'b0)
      $display("FAIL reset_idx: got %b want 000000", {bus.pe_kx, bus.pe_ky, bus.bank});
    else n_pass++;
    n_checks++;
    if (bus.reg_array_cmd !== HOLD)
      $display("FAIL reset_cmd: got %0d want %0d", bus.reg_array_cmd, HOLD);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit gd;
    reg_array_cmd_e e;
    g_mode = 0;
    build_model(1, 0);
    run_tile(1, 0, 60, gd);
    n_checks++; if (gd !== 1'b1) $display("FAIL basic_done_seen: got %0d want 1", gd); else n_pass++;
    for (int c = 0; c <= 12; c++) begin
      if (c == 1) e = CLEAR;
      else if (c >= 2 && c <= 10 && (c - 2) % 3 == 0) e = LOAD;
      else if (c >= 2 && c <= 10) e = SHIFT;
      else e = HOLD;
      n_checks++;
      if (cmd_tr[c] !== e) $display("FAIL basic_cmd[%0d]: got %0d want %0d", c, cmd_tr[c], e);
      else n_pass++;
      n_checks++;
      if (pv_tr[c] !== (c >= 3 && c <= 11))
        $display("FAIL basic_pe_valid[%0d]: got %0d want %0d", c, pv_tr[c], (c >= 3 && c <= 11));
      else n_pass++;
      n_checks++;
      if (busy_tr[c] !== (c >= 1))
        $display("FAIL basic_busy[%0d]: got %0d want %0d", c, busy_tr[c], (c >= 1));
      else n_pass++;
    end
    n_checks++; if (busy_tr[13] !== 1'b0) $display("FAIL basic_busy_end: got %0d want 0", busy_tr[13]); else n_pass++;
    n_checks++; if (last_tr[11] !== 1'b1) $display("FAIL basic_last: got %0d want 1", last_tr[11]); else n_pass++;
    n_checks++; if (done_tr[12] !== 1'b1) $display("FAIL basic_done12: got %0d want 1", done_tr[12]); else n_pass++;
    n_checks++; if (cnt_done() != 1) $display("FAIL basic_done_cnt: got %0d want 1", cnt_done()); else n_pass++;
    n_checks++; if (cnt_rd() != 3) $display("FAIL basic_buf_rd: got %0d want 3", cnt_rd()); else n_pass++;
    n_checks++; if (load_errs() != 0) $display("FAIL basic_banks: got %0d errs want 0", load_errs()); else n_pass++;
    n_checks++; if (beat_errs() != 0) $display("FAIL basic_beats: got %0d errs want 0", beat_errs()); else n_pass++;
  endtask

  task automatic test_rows2_bank();
    bit gd;
    g_mode = 0;
    build_model(2, 3);
    run_tile(2, 3, 80, gd);
    n_checks++; if (gd !== 1'b1) $display("FAIL rows2_done_seen: got %0d want 1", gd); else n_pass++;
    n_checks++; if (done_tr[21] !== 1'b1) $display("FAIL rows2_done21: got %0d want 1", done_tr[21]); else n_pass++;
    n_checks++; if (cnt_rd() != 6) $display("FAIL rows2_buf_rd: got %0d want 6", cnt_rd()); else n_pass++;
    n_checks++; if (load_errs() != 0) $display("FAIL rows2_banks: got %0d errs want 0", load_errs()); else n_pass++;
    n_checks++; if (beat_errs() != 0) $display("FAIL rows2_beats: got %0d errs want 0", beat_errs()); else n_pass++;
  endtask

  task automatic test_buf_stall();
    bit gd;
    g_mode = 1;
    build_model(1, 1);
    run_tile(1, 1, 60, gd);
    for (int c = 5; c <= 8; c++) begin
      n_checks++;
      if (cmd_tr[c] !== HOLD || rd_tr[c] !== 1'b0)
        $display("FAIL bufstall_hold[%0d]: got cmd %0d rd %0d want 0 0", c, cmd_tr[c], rd_tr[c]);
      else n_pass++;
    end
    n_checks++; if (cmd_tr[9] !== LOAD) $display("FAIL bufstall_load9: got %0d want %0d", cmd_tr[9], LOAD); else n_pass++;
    n_checks++; if (done_tr[16] !== 1'b1) $display("FAIL bufstall_done16: got %0d want 1", done_tr[16]); else n_pass++;
    n_checks++; if (load_errs() != 0) $display("FAIL bufstall_banks: got %0d errs want 0", load_errs()); else n_pass++;
    n_checks++; if (beat_errs() != 0) $display("FAIL bufstall_beats: got %0d errs want 0", beat_errs()); else n_pass++;
  endtask

  task automatic test_pe_stall();
    bit gd;
    g_mode = 2;
    build_model(1, 2);
    run_tile(1, 2, 60, gd);
    for (int c = 4; c <= 6; c++) begin
      n_checks++;
      if (cmd_tr[c] !== HOLD || pv_tr[c] !== 1'b1 || kx_tr[c] !== 2'd1 || ky_tr[c] !== 2'd0)
        $display("FAIL pestall_hold[%0d]: got cmd %0d pv %0d kx %0d ky %0d want 0 1 1 0",
                 c, cmd_tr[c], pv_tr[c], kx_tr[c], ky_tr[c]);
      else n_pass++;
    end
    n_checks++; if (cmd_tr[7] !== SHIFT) $display("FAIL pestall_shift7: got %0d want %0d", cmd_tr[7], SHIFT); else n_pass++;
    n_checks++; if (done_tr[15] !== 1'b1) $display("FAIL pestall_done15: got %0d want 1", done_tr[15]); else n_pass++;
    n_checks++; if (beat_errs() != 0) $display("FAIL pestall_beats: got %0d errs want 0", beat_errs()); else n_pass++;
  endtask

  task automatic test_zero_rows_and_busy_start();
    bit gd;
    int act;
    g_mode = 0;
    run_tile(0, 1, 20, gd);
    act = 0;
    for (int c = 0; c < ntr; c++) if (cmd_tr[c] !== HOLD || rd_tr[c] || pv_tr[c]) act++;
    n_checks++; if (done_tr[1] !== 1'b1) $display("FAIL zero_done1: got %0d want 1", done_tr[1]); else n_pass++;
    n_checks++; if (busy_tr[1] !== 1'b1 || busy_tr[2] !== 1'b0)
      $display("FAIL zero_busy: got %0d%0d want 10", busy_tr[1], busy_tr[2]); else n_pass++;
    n_checks++; if (act != 0) $display("FAIL zero_activity: got %0d cycles want 0", act); else n_pass++;
    g_xs1 = 4;
    g_xs2 = 12;
    build_model(1, 0);
    run_tile(1, 0, 60, gd);
    g_xs1 = -1;
    g_xs2 = -1;
    n_checks++; if (cnt_done() != 1 || done_tr[12] !== 1'b1)
      $display("FAIL busystart_done: got cnt %0d d12 %0d want 1 1", cnt_done(), done_tr[12]); else n_pass++;
    n_checks++; if (busy_tr[14] !== 1'b0 || busy_tr[15] !== 1'b0)
      $display("FAIL busystart_idle: got %0d%0d want 00", busy_tr[14], busy_tr[15]); else n_pass++;
    n_checks++; if (beat_errs() != 0) $display("FAIL busystart_beats: got %0d errs want 0", beat_errs()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit gd;
    g_mode = 0;
    g_rst = 6;
    run_tile(2, 1, 16, gd);
    g_rst = -1;
    n_checks++; if (gd !== 1'b0) $display("FAIL rstmid_no_done: got %0d want 0", gd); else n_pass++;
    n_checks++;
    if ({busy_tr[7], rd_tr[7], pv_tr[7], last_tr[7], kx_tr[7], ky_tr[7], bank_tr[7]} !== 10'b0)
      $display("FAIL rstmid_state7: got %b want 0", {busy_tr[7], rd_tr[7], pv_tr[7], last_tr[7],
               kx_tr[7], ky_tr[7], bank_tr[7]});
    else n_pass++;
    n_checks++; if (cmd_tr[7] !== HOLD) $display("FAIL rstmid_cmd7: got %0d want 0", cmd_tr[7]); else n_pass++;
    build_model(1, 3);
    run_tile(1, 3, 60, gd);
    n_checks++; if (done_tr[12] !== 1'b1) $display("FAIL rstmid_fresh_done: got %0d want 1", done_tr[12]); else n_pass++;
    n_checks++; if (beat_errs() != 0) $display("FAIL rstmid_fresh_beats: got %0d errs want 0", beat_errs()); else n_pass++;
    n_checks++; if (load_errs() != 0) $display("FAIL rstmid_fresh_banks: got %0d errs want 0", load_errs()); else n_pass++;
  endtask

  task automatic test_random();
    bit gd;
    int rows, b0, cons, stab;
    g_mode = 3;
    for (int it = 0; it < 6; it++) begin
      rows = $urandom_range(1, 3);
      b0 = $urandom_range(0, 3);
      build_model(rows, b0);
      run_tile(rows, b0, 480, gd);
      cons = 0;
      stab = 0;
      for (int c = 0; c < ntr; c++) if ((cmd_tr[c] === LOAD) !== rd_tr[c]) cons++;
      for (int c = 0; c + 1 < ntr; c++)
        if (pv_tr[c] && !pr_tr[c] && (pv_tr[c+1] !== 1'b1 || kx_tr[c+1] !== kx_tr[c] ||
            ky_tr[c+1] !== ky_tr[c] || last_tr[c+1] !== last_tr[c] || cmd_tr[c] !== HOLD))
          stab++;
      n_checks++; if (gd !== 1'b1) $display("FAIL rand%0d_done_seen: got %0d want 1", it, gd); else n_pass++;
      n_checks++; if (cnt_done() != 1) $display("FAIL rand%0d_done_cnt: got %0d want 1", it, cnt_done()); else n_pass++;
      n_checks++; if (beat_errs() != 0) $display("FAIL rand%0d_beats: got %0d errs want 0", it, beat_errs()); else n_pass++;
      n_checks++; if (load_errs() != 0) $display("FAIL rand%0d_banks: got %0d errs want 0", it, load_errs()); else n_pass++;
      n_checks++; if (cons != 0) $display("FAIL rand%0d_rd_vs_load: got %0d errs want 0", it, cons); else n_pass++;
      n_checks++; if (stab != 0) $display("FAIL rand%0d_stall_stable: got %0d errs want 0", it, stab); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cfg_rows = '0;
    bus.cfg_bank0 = '0;
    bus.buf_valid = 1'b0;
    bus.pe_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_rows2_bank();
    test_buf_stall();
    test_pe_stall();
    test_zero_rows_and_busy_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
